// File: rtl/fp_pkg.sv
// Shared floating-point constants, field offsets and the divider state encoding
// used by the arithmetic datapath blocks.
package fp_pkg;

  localparam int FP_BIAS = 127;
  localparam int EXP_W   = 8;
  localparam int MANT_W  = 23;

  localparam int SIGN_BIT = 31;
  localparam int EXP_MSB  = 30;
  localparam int EXP_LSB  = 23;
  localparam int MANT_MSB = 22;
  localparam int MANT_LSB = 0;

  localparam logic [31:0] FP_INF = 32'h7F80_0000;

  typedef enum logic [1:0] {
    IDLE,
    DIVIDE,
    NORM,
    DONE
  } state_t;

endpackage

// File: rtl/fp_divider_if.sv
// Operand/result handshake bundle for the sequential floating-point divider.
interface fp_divider_if;

  logic        in_valid;
  logic        in_ready;
  logic [31:0] num1;
  logic [31:0] num2;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] final_quotient;
  logic        div_by_zero;

  modport master (
    output in_valid, num1, num2, out_ready,
    input  in_ready, out_valid, final_quotient, div_by_zero
  );

  modport slave (
    input  in_valid, num1, num2, out_ready,
    output in_ready, out_valid, final_quotient, div_by_zero
  );

endinterface

// File: rtl/fp_div_step.sv
// One radix-2 restoring division iteration: compare, conditionally subtract,
// then shift the partial remainder left.
module fp_div_step #(
  parameter int SIG_W = 24
) (
  input  logic [SIG_W:0]   i_rem,
  input  logic [SIG_W-1:0] i_div,
  output logic [SIG_W:0]   o_rem,
  output logic             o_qBit
);

  logic [SIG_W:0] w_diff;

  assign o_qBit = (i_rem >= {1'b0, i_div});
  assign w_diff = o_qBit ? (i_rem - {1'b0, i_div}) : i_rem;
  assign o_rem  = w_diff << 1;

endmodule

// File: rtl/fp_divider.sv
// Sequential single-precision divider: 25 restoring iterations, truncating
// normalisation and wrap-around exponent arithmetic, behind valid/ready.
module fp_divider #(
  parameter int MANT_W = fp_pkg::MANT_W,
  parameter int EXP_W  = fp_pkg::EXP_W,
  parameter int BIAS   = fp_pkg::FP_BIAS
) (
  input logic         clk,
  input logic         rst,
  fp_divider_if.slave bus
);

  import fp_pkg::*;

  localparam int SIG_W = MANT_W + 1;
  localparam int REM_W = MANT_W + 2;

  state_t             r_state;
  state_t             w_nextState;
  logic [REM_W-1:0]   r_rem;
  logic [REM_W-1:0]   r_quot;
  logic [SIG_W-1:0]   r_div;
  logic [4:0]         r_count;
  logic               r_sign;
  logic               r_divZero;
  logic               r_numZero;
  logic [EXP_W-1:0]   r_exp1;
  logic [EXP_W-1:0]   r_exp2;
  logic [31:0]        r_result;
  logic               r_dbz;

  logic               w_accept;
  logic [REM_W-1:0]   w_nextRem;
  logic               w_qBit;
  logic [EXP_W-1:0]   w_expBase;
  logic [EXP_W-1:0]   w_expNorm;
  logic [MANT_W-1:0]  w_mant;
  logic [31:0]        w_normResult;

  assign w_accept           = bus.in_valid & bus.in_ready;
  assign bus.in_ready       = (r_state == IDLE);
  assign bus.out_valid      = (r_state == DONE);
  assign bus.final_quotient = r_result;
  assign bus.div_by_zero    = r_dbz;

  fp_div_step #(.SIG_W(SIG_W)) u_step (
    .i_rem  (r_rem),
    .i_div  (r_div),
    .o_rem  (w_nextRem),
    .o_qBit (w_qBit)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_nextState;
  end

  always_comb begin
    w_nextState = r_state;
    case (r_state)
      IDLE:    if (w_accept) w_nextState = DIVIDE;
      DIVIDE:  if (r_count == 5'd0) w_nextState = NORM;
      NORM:    w_nextState = DONE;
      DONE:    if (bus.out_ready) w_nextState = IDLE;
      default: w_nextState = IDLE;
    endcase
  end

  // Quotient bits shift in MSB-first, so after 25 steps the first bit sits in Q[24].
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rem     <= '0;
      r_quot    <= '0;
      r_div     <= '0;
      r_count   <= '0;
      r_sign    <= 1'b0;
      r_divZero <= 1'b0;
      r_numZero <= 1'b0;
      r_exp1    <= '0;
      r_exp2    <= '0;
      r_result  <= '0;
      r_dbz     <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_rem     <= {2'b01, bus.num1[MANT_MSB:MANT_LSB]};
            r_div     <= {1'b1, bus.num2[MANT_MSB:MANT_LSB]};
            r_quot    <= '0;
            r_count   <= 5'(REM_W - 1);
            r_sign    <= bus.num1[SIGN_BIT] ^ bus.num2[SIGN_BIT];
            r_exp1    <= bus.num1[EXP_MSB:EXP_LSB];
            r_exp2    <= bus.num2[EXP_MSB:EXP_LSB];
            r_divZero <= (bus.num2[EXP_MSB:EXP_LSB] == '0);
            r_numZero <= (bus.num1[EXP_MSB:0] == '0);
          end
        end
        DIVIDE: begin
          r_rem  <= w_nextRem;
          r_quot <= {r_quot[REM_W-2:0], w_qBit};
          if (r_count != 5'd0) r_count <= r_count - 5'd1;
        end
        NORM: begin
          r_result <= w_normResult;
          r_dbz    <= r_divZero;
        end
        default: ;
      endcase
    end
  end

  // Zero divisor wins over zero dividend; otherwise normalise by the quotient MSB.
  always_comb begin
    w_expBase = r_exp1 - r_exp2 + EXP_W'(BIAS);
    w_expNorm = w_expBase;
    w_mant    = r_quot[MANT_W:1];
    if (!r_quot[REM_W-1]) begin
      w_expNorm = w_expBase - EXP_W'(1);
      w_mant    = r_quot[MANT_W-1:0];
    end
    if (r_divZero)      w_normResult = {r_sign, FP_INF[30:0]};
    else if (r_numZero) w_normResult = {r_sign, 31'b0};
    else                w_normResult = {r_sign, w_expNorm, w_mant};
  end

endmodule

// File: tb/tb_fp_divider.sv
// Self-checking bench for fp_divider: directed vector table, random operands
// against an integer-division reference, and handshake/reset corner sequences.
module tb_fp_divider;

  logic clk = 1'b0;
  logic rst;

  fp_divider_if bus();

  fp_divider dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] q;
    logic        dz;
  } vec_t;

  vec_t vecs[$];

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Quotient of the 24-bit significands scaled by 2^24, then normalised by its magnitude.
  function automatic void modelDiv(input logic [31:0] a, input logic [31:0] b,
                                   output logic [31:0] q, output logic dz);
    logic            s;
    longint unsigned ma, mb, quo;
    logic [63:0]     qv;
    logic [7:0]      e;
    s  = a[31] ^ b[31];
    dz = 1'b0;
    if (b[30:23] == 8'h00) begin
      q  = {s, 8'hFF, 23'h0};
      dz = 1'b1;
    end else if (a[30:0] == 31'h0) begin
      q = {s, 31'h0};
    end else begin
      ma  = {40'h0, 1'b1, a[22:0]};
      mb  = {40'h0, 1'b1, b[22:0]};
      quo = (ma << 24) / mb;
      qv  = quo;
      e   = a[30:23] - b[30:23] + 8'd127;
      if (quo >= (64'd1 << 24)) begin
        q = {s, e, qv[23:1]};
      end else begin
        e = e - 8'd1;
        q = {s, e, qv[22:0]};
      end
    end
  endfunction

  task automatic waitResult(output int lat);
    lat = 0;
    while (bus.out_valid !== 1'b1 && lat < 60) begin
      @(posedge clk);
      #1;
      lat++;
    end
  endtask

  task automatic applyStimulus(input logic [31:0] a, input logic [31:0] b, output int lat);
    @(negedge clk);
    checkOutput("inReadyBeforeAccept", bus.in_ready, 1);
    bus.num1     = a;
    bus.num2     = b;
    bus.in_valid = 1'b1;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    waitResult(lat);
  endtask

  task automatic transferResult();
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.out_ready = 1'b0;
    checkOutput("outValidAfterXfer", bus.out_valid, 0);
    checkOutput("inReadyAfterXfer", bus.in_ready, 1);
  endtask

  task automatic runAndCheck(input string name, input logic [31:0] a, input logic [31:0] b,
                             input logic [31:0] q, input logic dz);
    int lat;
    applyStimulus(a, b, lat);
    checkOutput({name, "_latency"}, lat, 26);
    checkOutput({name, "_quotient"}, bus.final_quotient, q);
    checkOutput({name, "_divByZero"}, bus.div_by_zero, dz);
    transferResult();
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog actual=timeout required=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int          lat;
    logic [31:0] a, b, q;
    logic        dz;

    rst           = 1'b1;
    bus.in_valid  = 1'b0;
    bus.num1      = '0;
    bus.num2      = '0;
    bus.out_ready = 1'b0;

    #3;
    checkOutput("rstInReady", bus.in_ready, 1);
    checkOutput("rstOutValid", bus.out_valid, 0);
    checkOutput("rstQuotient", bus.final_quotient, 32'h0);
    checkOutput("rstDivByZero", bus.div_by_zero, 0);
    @(negedge clk);
    rst = 1'b0;

    vecs.push_back('{32'h40C00000, 32'h40000000, 32'h40400000, 1'b0});
    vecs.push_back('{32'h3F800000, 32'h3FC00000, 32'h3F2AAAAA, 1'b0});
    vecs.push_back('{32'h3F800000, 32'h40400000, 32'h3EAAAAAA, 1'b0});
    vecs.push_back('{32'hBFC00000, 32'h3F000000, 32'hC0400000, 1'b0});
    vecs.push_back('{32'h3F800000, 32'h00000000, 32'h7F800000, 1'b1});
    vecs.push_back('{32'h00000000, 32'h40000000, 32'h00000000, 1'b0});
    vecs.push_back('{32'h80000000, 32'h3F800000, 32'h80000000, 1'b0});
    vecs.push_back('{32'h00000000, 32'h00000000, 32'h7F800000, 1'b1});
    vecs.push_back('{32'h3F800000, 32'h80000000, 32'hFF800000, 1'b1});
    vecs.push_back('{32'h7F000000, 32'h00800000, 32'h3E000000, 1'b0});
    vecs.push_back('{32'h00800000, 32'h7F000000, 32'h41000000, 1'b0});
    vecs.push_back('{32'h3F800000, 32'h3F800000, 32'h3F800000, 1'b0});
    vecs.push_back('{32'h40000000, 32'h3FFFFFFF, 32'h3F800000, 1'b0});

    foreach (vecs[i]) begin
      runAndCheck($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].q, vecs[i].dz);
    end

    for (int n = 0; n < 30; n++) begin
      a = $urandom;
      b = $urandom;
      if ($urandom_range(0, 9) == 0) b[30:23] = 8'h00;
      if ($urandom_range(0, 9) == 0) a[30:0] = 31'h0;
      modelDiv(a, b, q, dz);
      runAndCheck($sformatf("rand%0d", n), a, b, q, dz);
    end

    // Backpressure: result must hold and new operands must be refused.
    applyStimulus(32'h40C00000, 32'h40000000, lat);
    checkOutput("bpLatency", lat, 26);
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      bus.in_valid = (c % 2 == 0);
      bus.num1     = 32'h3F800000;
      bus.num2     = 32'h40400000;
      checkOutput($sformatf("bpQuotient%0d", c), bus.final_quotient, 32'h40400000);
      checkOutput($sformatf("bpInReady%0d", c), bus.in_ready, 0);
      checkOutput($sformatf("bpOutValid%0d", c), bus.out_valid, 1);
    end
    @(negedge clk);
    bus.in_valid = 1'b0;
    transferResult();
    bus.num1     = 32'hBFC00000;
    bus.num2     = 32'h3F000000;
    bus.in_valid = 1'b1;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    checkOutput("nextAccepted", bus.in_ready, 0);
    waitResult(lat);
    checkOutput("nextLatency", lat, 26);
    checkOutput("nextQuotient", bus.final_quotient, 32'hC0400000);
    transferResult();

    // out_ready held high ahead of the result changes nothing about timing.
    @(negedge clk);
    bus.out_ready = 1'b1;
    applyStimulus(32'h3F800000, 32'h40400000, lat);
    checkOutput("earlyReadyLatency", lat, 26);
    checkOutput("earlyReadyQuotient", bus.final_quotient, 32'h3EAAAAAA);
    transferResult();

    // Reset in the middle of DIVIDE discards the operation.
    @(negedge clk);
    bus.num1     = 32'h3F800000;
    bus.num2     = 32'h3FC00000;
    bus.in_valid = 1'b1;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    repeat (12) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    checkOutput("midRstOutValid", bus.out_valid, 0);
    checkOutput("midRstInReady", bus.in_ready, 1);
    checkOutput("midRstQuotient", bus.final_quotient, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    runAndCheck("afterRst", 32'h40C00000, 32'h40000000, 32'h40400000, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
